// File: rtl/morse_tx_scheduler.sv
// Message scheduler: buffers ASCII characters and paces them into the Morse
// encoder, inserting inter-character and word gaps measured in Tick units.
module morse_tx_scheduler #(
    parameter int DEPTH    = 16,
    parameter int CHAR_GAP = 3,
    parameter int WORD_GAP = 7
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [6:0]                 RxData,
    input  logic                       RxValid,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic                       Tick,
    input  logic                       EncBusy,
    output logic [6:0]                 CharOut,
    output logic                       CharLoad,
    output logic                       EncAbort,
    output logic                       Busy,
    output logic                       Empty,
    output logic                       Full,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int GW = $clog2(WORD_GAP+1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [GW-1:0] CHAR_TGT = GW'(CHAR_GAP);
    localparam logic [GW-1:0] WORD_TGT = GW'(WORD_GAP - CHAR_GAP);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [6:0]    SPACE    = 7'd32;

    function automatic logic char_ok(input logic [6:0] c);
        return ((c >= 7'd65) && (c <= 7'd90)) || ((c >= 7'd48) && (c <= 7'd57)) || (c == SPACE);
    endfunction

    logic [6:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_nxt_s;
    logic [2:0]    state_r, state_nxt_s;
    logic [GW-1:0] gap_cnt_r, gap_tgt_r;
    logic [6:0]    char_out_r, head_s;
    logic          char_load_r, enc_abort_r, busy_r, empty_r, full_r, err_r;
    logic          push_s, pop_s, err_s;

    assign head_s = mem_r[rd_ptr_r];
    // LOAD is only entered with a non-empty FIFO, so the pop never underflows.
    assign pop_s  = (state_r == S_LOAD) && !Abort;
    assign push_s = RxValid && !Abort && char_ok(RxData) && (!full_r || pop_s);
    assign err_s  = RxValid && !Abort && !push_s;

    // Occupancy after this cycle's push/pop/flush.
    always_comb begin
        count_nxt_s = count_r;
        if (Abort) begin
            count_nxt_s = '0;
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Next-state logic; Abort overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Start && !empty_r) state_nxt_s = S_LOAD;
                else                   state_nxt_s = S_IDLE;
            end
            S_LOAD: begin
                if (head_s == SPACE) state_nxt_s = S_GAP;
                else                 state_nxt_s = S_ARM;
            end
            S_ARM:  state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (!EncBusy) state_nxt_s = S_GAP;
                else          state_nxt_s = S_WAIT;
            end
            S_GAP: begin
                if (gap_cnt_r != gap_tgt_r)       state_nxt_s = S_GAP;
                else if (count_nxt_s == {CW{1'b0}}) state_nxt_s = S_IDLE;
                else                              state_nxt_s = S_LOAD;
            end
            default: state_nxt_s = S_IDLE;
        endcase
        if (Abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Character storage; contents need no reset because pointers qualify them.
    always_ff @(posedge CLK) begin
        if (push_s) mem_r[wr_ptr_r] <= RxData;
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (Abort) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CW{1'b0}});
            full_r  <= (count_nxt_s == DEPTH_C);
            err_r   <= err_s;
        end
    end

    // Sequencer state, gap timing and encoder-facing outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= S_IDLE;
            gap_cnt_r   <= '0;
            gap_tgt_r   <= '0;
            char_out_r  <= 7'd0;
            char_load_r <= 1'b0;
            enc_abort_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != S_IDLE);
            enc_abort_r <= Abort;
            char_load_r <= 1'b0;
            // Counter is held at zero outside GAP, so it starts clean on entry.
            if (Abort || (state_r != S_GAP)) begin
                gap_cnt_r <= '0;
            end else if (Tick && (gap_cnt_r != gap_tgt_r)) begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end
            if (state_r == S_LOAD && !Abort) begin
                if (head_s == SPACE) begin
                    gap_tgt_r <= WORD_TGT;
                end else begin
                    char_out_r  <= head_s;
                    char_load_r <= 1'b1;
                end
            end
            if (state_r == S_WAIT && !EncBusy && !Abort) gap_tgt_r <= CHAR_TGT;
        end
    end

    assign CharOut  = char_out_r;
    assign CharLoad = char_load_r;
    assign EncAbort = enc_abort_r;
    assign Busy     = busy_r;
    assign Empty    = empty_r;
    assign Full     = full_r;
    assign Count    = count_r;
    assign Err      = err_r;
endmodule

// File: doc/morse_tx_scheduler.md
# morse_tx_scheduler

Message scheduler in front of the Morse encoder datapath. Buffers 7-bit ASCII characters into a small FIFO, and on `Start` hands them one at a time to the encoder. Inserts the inter-character gap after each character, and turns a space into a word gap. Sits between the character source (`RxData`/`Start`) and the encoder that drives `Y`.

## Interface
- `DEPTH`, 16: FIFO depth in characters (power of 2, ≥2)
- `CHAR_GAP`, 3: unit ticks of silence after each encoded character
- `WORD_GAP`, 7: total unit ticks of silence for a word break (`WORD_GAP` > `CHAR_GAP`)
- `CLK`  in  1  system clock, all logic on rising edge
- `RST`  in  1  asynchronous, active-low reset
- `RxData`  in  7  ASCII character to enqueue
- `RxValid`  in  1  write strobe for `RxData`, one character per cycle high
- `Start`  in  1  begin transmitting buffered message (sampled in IDLE only)
- `Abort`  in  1  flush FIFO, stop transmission
- `Tick`  in  1  one-cycle pulse per Morse time unit
- `EncBusy`  in  1  encoder keying a character
- `CharOut`  out  7  character presented to encoder (registered)
- `CharLoad`  out  1  one-cycle pulse: encoder captures `CharOut`
- `EncAbort`  out  1  one-cycle pulse to encoder, registered copy of `Abort`
- `Busy`  out  1  high in every state except IDLE
- `Empty`  out  1  FIFO empty
- `Full`  out  1  FIFO full
- `Count`  out  $clog2(DEPTH+1)  characters in FIFO
- `Err`  out  1  one-cycle pulse: write rejected

## Operation
- Accepted codes: 65–90 ('A'–'Z'), 48–57 ('0'–'9'), and 32 (space). `RxValid` with any other code is dropped and `Err` pulses.
- Write while `Full` with no pop in the same cycle: the character is dropped and `Err` pulses.
- Simultaneous accepted write and pop: both take effect and `Count` is unchanged.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- States:
  - IDLE: `Start`=1 and `Empty`=0 → LOAD. `Start` with `Empty`=1 is ignored.
  - LOAD: pop the head character.
    - If it is not a space: `CharOut` ← char, `CharLoad`=1, go to ARM.
    - If it is a space: no `CharLoad`, go to GAP with target `WORD_GAP-CHAR_GAP`.
  - ARM: one cycle; `EncBusy` is not checked. Go to WAIT_ENC.
  - WAIT_ENC: when `EncBusy`=0, go to GAP with target `CHAR_GAP`.
  - GAP: the gap counter clears on entry and increments on each `Tick`. When counter == target, go to LOAD if `Empty`=0, else go to IDLE.
- Characters written during transmission are sent in the same run. A run ends only when the FIFO drains.
- `Abort` has priority over all other events. On the next edge:
  - state = IDLE
  - FIFO flushed (pointers and `Count` = 0)
  - gap counter = 0
  - `EncAbort`=1 for one cycle
  - any same-cycle write is discarded with no `Err`
- `Start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `CharOut`=0, `CharLoad`=0, `EncAbort`=0, `Err`=0, `Busy`=0
  - `Empty`=1, `Full`=0, `Count`=0
- `Count`/`Empty`/`Full` update on the edge after a write or pop.
- `Start` sampled at edge N → state LOAD after edge N. `CharLoad`/`CharOut` are valid after edge N+1 (2-cycle latency).
- The encoder must raise `EncBusy` by the cycle after it samples `CharLoad`. ARM covers that cycle.
- Gap length is exactly the target number of `Tick` pulses counted from GAP entry. A `Tick` in the same cycle as GAP entry is not counted.
- Gap targets: between two letters, `CHAR_GAP`. Letter, space, letter: `CHAR_GAP` + (`WORD_GAP-CHAR_GAP`) = `WORD_GAP` ticks.
- Trailing space: the word gap is still timed, then IDLE.
- `Err` and `EncAbort` are exactly one cycle long.
- Reset asserted mid-run: everything returns to reset values immediately (asynchronous). `CharLoad` must not glitch high.

## Test plan
- Reset, then write 65,66,67 ('ABC') at 1/cycle, pulse `Start`, and model `EncBusy` high for 10 cycles after each `CharLoad` with `Tick` every 4 cycles. Required:
  - `CharOut` sequence 65,66,67
  - exactly 3 `CharLoad` pulses
  - 3 `Tick`s between each `EncBusy` fall and the next `CharLoad`
  - `Busy` falls after the last gap, and `Count`=0
- Write 65,32,66 ('A B') and run. Required: 2 `CharLoad` pulses, and exactly 7 `Tick`s between `EncBusy` fall after 'A' and `CharLoad` of 'B'.
- Write 17 accepted characters into an idle FIFO (`DEPTH`=16). Required: `Full`=1 after the 16th, the 17th dropped with `Err`=1 for one cycle, and `Count`=16.
- Write 97 ('a') and 35 ('#'). Required: `Err` pulses twice, and `Count`=0, `Empty`=1.
- Start a 5-character run and assert `Abort` during WAIT_ENC of the 2nd character. Required:
  - next cycle `Busy`=0, `Count`=0, `EncAbort`=1 for one cycle
  - no further `CharLoad`
- Pulse `Start` with an empty FIFO, then pulse `Start` again mid-run. Required: first pulse leaves `Busy`=0; second has no effect on the `CharOut` sequence. Also drive `RST` low mid-GAP and confirm all outputs return to reset values without waiting for `CLK`.
